// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dpram_pkg;

    typedef enum logic {CLEAR, RUN} dpram_state_t;

    // Upper bounds for the generic merge helper; callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_LANES  = 256;

    function automatic int unsigned num_lanes(input int unsigned data_w, input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_LANES-1:0]  bweb,
        input int unsigned           lanes,
        input int unsigned           byte_w
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_word;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if ((i / byte_w) < lanes && !bweb[8'(i / byte_w)])
                r[8'(i)] = new_word[8'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read pipeline of depth RD_LAT; OEB gates only the final stage.
module dpram_port_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic              oeb,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] fin;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_q, s2_q;
            logic              v1_q;
            // Second stage follows the first only after a load, so idle cycles hold data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q <= '0;
                    s2_q <= '0;
                    v1_q <= 1'b0;
                end else begin
                    if (ld)   s1_q <= d;
                    if (v1_q) s2_q <= s1_q;
                    v1_q <= ld;
                end
            end
            assign fin = s2_q;
        end else begin : g_lat1
            logic [DATA_W-1:0] s1_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  s1_q <= '0;
                else if (ld) s1_q <= d;
            end
            assign fin = s1_q;
        end
    endgenerate

    assign q = oeb ? '0 : fin;

endmodule

// File: rtl/dpram_cb_param.sv
// Parametrised dual-port RAM: byte masks, RDW mode, collision flag, post-reset clear.
module dpram_cb_param
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned DEPTH    = 2**ADDR_W,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned INIT_CLR = 1
) (
    input  logic                     CLK,
    input  logic                     RSTB,
    input  logic                     CSB1,
    input  logic                     CSB2,
    input  logic                     WEB1,
    input  logic                     WEB2,
    input  logic                     OEB1,
    input  logic                     OEB2,
    input  logic [DATA_W/BYTE_W-1:0] BWEB1,
    input  logic [DATA_W/BYTE_W-1:0] BWEB2,
    input  logic [ADDR_W-1:0]        A1,
    input  logic [ADDR_W-1:0]        A2,
    input  logic [DATA_W-1:0]        I1,
    input  logic [DATA_W-1:0]        I2,
    output logic [DATA_W-1:0]        O1,
    output logic [DATA_W-1:0]        O2,
    output logic                     RDY,
    output logic                     COLL
);

    localparam int unsigned NL = num_lanes(DATA_W, BYTE_W);

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NL-1:0]     bweb
    );
        return DATA_W'(byte_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word),
                                  MAX_LANES'(bweb), NL, BYTE_W));
    endfunction

    dpram_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              coll_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              rdy, act1, act2, in1, in2, wr1, wr2, same, ww;
    logic [DATA_W-1:0] old1, old2, w1_word, w2_word, comb_word, new_a1, new_a2;

    assign rdy  = (state_q == RUN);
    assign act1 = rdy & RSTB & ~CSB1;
    assign act2 = rdy & RSTB & ~CSB2;
    assign in1  = 32'(A1) < DEPTH;
    assign in2  = 32'(A2) < DEPTH;
    assign wr1  = act1 & ~WEB1 & in1;
    assign wr2  = act2 & ~WEB2 & in2;
    assign same = act1 & act2 & (A1 == A2);
    assign ww   = wr1 & wr2 & same;

    assign old1      = in1 ? mem[A1] : '0;
    assign old2      = in2 ? mem[A2] : '0;
    assign w1_word   = merge(old1, I1, BWEB1);
    assign w2_word   = merge(old2, I2, BWEB2);
    // Port 2 merged first, port 1 on top: port 1 wins shared lanes.
    assign comb_word = merge(w2_word, I1, BWEB1);

    always_comb begin
        new_a1 = old1;
        new_a2 = old2;
        if (ww) begin
            new_a1 = comb_word;
            new_a2 = comb_word;
        end else begin
            if (wr1)              new_a1 = w1_word;
            else if (wr2 && same) new_a1 = w2_word;
            if (wr2)              new_a2 = w2_word;
            else if (wr1 && same) new_a2 = w1_word;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && cnt_q == ADDR_W'(DEPTH - 1))
            state_d = RUN;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= (INIT_CLR != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) cnt_q <= cnt_q + 1'b1;
            coll_q  <= same & in1 & (~WEB1 | ~WEB2);
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr1)        mem[A1] <= new_a1;
            if (wr2 && !ww) mem[A2] <= w2_word;
        end
    end

    dpram_port_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe1 (
        .clk(CLK), .rst_n(RSTB), .ld(act1), .oeb(OEB1),
        .d((RDW_MODE != 0) ? new_a1 : old1), .q(O1)
    );

    dpram_port_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe2 (
        .clk(CLK), .rst_n(RSTB), .ld(act2), .oeb(OEB2),
        .d((RDW_MODE != 0) ? new_a2 : old2), .q(O2)
    );

    assign RDY  = rdy;
    assign COLL = coll_q;

endmodule

// File: tb/tb_dpram_cb_param.sv
// Directed vector bench for dpram_cb_param: default, write-first and latency-2/depth-24 instances.
module tb_dpram_cb_param;

    logic        clk = 1'b0;
    logic        rstb, rstb2;
    logic        csb1, csb2, web1, web2, oeb1, oeb2;
    logic [3:0]  bweb1, bweb2;
    logic [4:0]  a1, a2;
    logic [31:0] i1, i2;

    logic [31:0] o1_0, o2_0, o1_1, o2_1, o1_2, o2_2;
    logic        rdy_0, rdy_1, rdy_2, coll_0, coll_1, coll_2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dpram_cb_param u0 (
        .CLK(clk), .RSTB(rstb), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .BWEB1(bweb1), .BWEB2(bweb2), .A1(a1), .A2(a2),
        .I1(i1), .I2(i2), .O1(o1_0), .O2(o2_0), .RDY(rdy_0), .COLL(coll_0)
    );

    dpram_cb_param #(.RDW_MODE(1)) u1 (
        .CLK(clk), .RSTB(rstb), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .BWEB1(bweb1), .BWEB2(bweb2), .A1(a1), .A2(a2),
        .I1(i1), .I2(i2), .O1(o1_1), .O2(o2_1), .RDY(rdy_1), .COLL(coll_1)
    );

    dpram_cb_param #(.RD_LAT(2), .DEPTH(24)) u2 (
        .CLK(clk), .RSTB(rstb2), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .BWEB1(bweb1), .BWEB2(bweb2), .A1(a1), .A2(a2),
        .I1(i1), .I2(i2), .O1(o1_2), .O2(o2_2), .RDY(rdy_2), .COLL(coll_2)
    );

    typedef struct {
        logic        csb1, web1; logic [3:0] bweb1; logic [4:0] a1; logic [31:0] i1;
        logic        csb2, web2; logic [3:0] bweb2; logic [4:0] a2; logic [31:0] i2;
        logic        oeb2;
        logic        c1; logic [31:0] e1;   // u0 O1
        logic        c2; logic [31:0] e2;   // u0 O2
        logic        cc; logic        ec;   // u0 COLL
        logic        ca; logic [31:0] ea;   // u1 O1
        logic        cb; logic [31:0] eb;   // u1 O2
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c1_, input logic w1_, input logic [3:0] b1_,
                         input logic [4:0] ad1, input logic [31:0] d1,
                         input logic c2_, input logic w2_, input logic [3:0] b2_,
                         input logic [4:0] ad2, input logic [31:0] d2, input logic oe2);
        @(negedge clk);
        csb1 = c1_; web1 = w1_; bweb1 = b1_; a1 = ad1; i1 = d1;
        csb2 = c2_; web2 = w2_; bweb2 = b2_; a2 = ad2; i2 = d2; oeb2 = oe2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{0,1,4'hf,5'h1f,32'h0,        1,1,4'hf,5'h00,32'h0,        0, 1,32'h0,        0,32'h0,        1,0, 0,32'h0,        0,32'h0};
        vecs[1]  = '{0,0,4'h0,5'h0f,32'h7b,       1,1,4'hf,5'h00,32'h0,        0, 0,32'h0,        0,32'h0,        1,0, 0,32'h0,        0,32'h0};
        vecs[2]  = '{0,0,4'h0,5'h0a,32'h67,       1,1,4'hf,5'h00,32'h0,        0, 0,32'h0,        0,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[3]  = '{0,1,4'hf,5'h0f,32'h0,        1,1,4'hf,5'h00,32'h0,        0, 1,32'h7b,       0,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[4]  = '{1,1,4'hf,5'h00,32'h0,        0,1,4'hf,5'h0a,32'h0,        0, 1,32'h7b,       1,32'h67,       0,0, 0,32'h0,        0,32'h0};
        vecs[5]  = '{1,1,4'hf,5'h00,32'h0,        1,1,4'hf,5'h00,32'h0,        1, 1,32'h7b,       1,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[6]  = '{1,1,4'hf,5'h00,32'h0,        1,1,4'hf,5'h00,32'h0,        0, 0,32'h0,        1,32'h67,       0,0, 0,32'h0,        0,32'h0};
        vecs[7]  = '{0,0,4'h0,5'h03,32'h11223344, 1,1,4'hf,5'h00,32'h0,        0, 0,32'h0,        0,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[8]  = '{0,0,4'ha,5'h03,32'hAABBCCDD, 1,1,4'hf,5'h00,32'h0,        0, 1,32'h11223344, 0,32'h0,        0,0, 1,32'h11BB33DD, 0,32'h0};
        vecs[9]  = '{0,1,4'hf,5'h03,32'h0,        1,1,4'hf,5'h00,32'h0,        0, 1,32'h11BB33DD, 0,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[10] = '{0,0,4'h0,5'h05,32'h1,        0,0,4'h0,5'h05,32'h2,        0, 0,32'h0,        0,32'h0,        1,1, 0,32'h0,        0,32'h0};
        vecs[11] = '{0,1,4'hf,5'h05,32'h0,        1,1,4'hf,5'h00,32'h0,        0, 1,32'h1,        0,32'h0,        1,0, 0,32'h0,        0,32'h0};
        vecs[12] = '{0,0,4'hc,5'h06,32'h11111111, 0,0,4'h6,5'h06,32'h22222222, 0, 0,32'h0,        0,32'h0,        1,1, 0,32'h0,        0,32'h0};
        vecs[13] = '{1,1,4'hf,5'h00,32'h0,        0,1,4'hf,5'h06,32'h0,        0, 0,32'h0,        1,32'h22001111, 1,0, 0,32'h0,        0,32'h0};
        vecs[14] = '{0,0,4'h0,5'h07,32'h12345678, 1,1,4'hf,5'h00,32'h0,        0, 0,32'h0,        0,32'h0,        0,0, 0,32'h0,        0,32'h0};
        vecs[15] = '{0,0,4'h0,5'h07,32'hDEAD0000, 0,1,4'hf,5'h07,32'h0,        0, 0,32'h0,        1,32'h12345678, 1,1, 1,32'hDEAD0000, 1,32'hDEAD0000};
        vecs[16] = '{0,1,4'hf,5'h07,32'h0,        0,1,4'hf,5'h07,32'h0,        0, 1,32'hDEAD0000, 1,32'hDEAD0000, 1,0, 0,32'h0,        1,32'hDEAD0000};

        csb1 = 1; csb2 = 1; web1 = 1; web2 = 1; oeb1 = 0; oeb2 = 0;
        bweb1 = '1; bweb2 = '1; a1 = '0; a2 = '0; i1 = '0; i2 = '0;
        rstb = 0; rstb2 = 0;
        #3;
        check("rst_o1", o1_0, 32'h0);
        check("rst_rdy", {31'b0, rdy_0}, 32'h0);
        check("rst_coll", {31'b0, coll_0}, 32'h0);

        @(negedge clk);
        rstb = 1; rstb2 = 1;
        n = 0;
        while (!rdy_0 && n < 100) begin
            step();
            n++;
        end
        check("clr_cycles", n, 32);
        check("clr_rdy_u1", {31'b0, rdy_1}, 32'h1);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].csb1, vecs[i].web1, vecs[i].bweb1, vecs[i].a1, vecs[i].i1,
                  vecs[i].csb2, vecs[i].web2, vecs[i].bweb2, vecs[i].a2, vecs[i].i2, vecs[i].oeb2);
            step();
            if (vecs[i].c1) check($sformatf("v%0d_o1", i), o1_0, vecs[i].e1);
            if (vecs[i].c2) check($sformatf("v%0d_o2", i), o2_0, vecs[i].e2);
            if (vecs[i].cc) check($sformatf("v%0d_coll", i), {31'b0, coll_0}, {31'b0, vecs[i].ec});
            if (vecs[i].ca) check($sformatf("v%0d_wf_o1", i), o1_1, vecs[i].ea);
            if (vecs[i].cb) check($sformatf("v%0d_wf_o2", i), o2_1, vecs[i].eb);
            if (i == 15)    check("wf_coll", {31'b0, coll_1}, 32'h1);
        end

        // Latency-2 / depth-24 instance: reset in the middle of its clear.
        drive(1,1,4'hf,5'h00,32'h0, 1,1,4'hf,5'h00,32'h0, 0);
        rstb2 = 0;
        @(negedge clk);
        rstb2 = 1;
        repeat (10) @(posedge clk);
        #2 rstb2 = 0;
        #1;
        check("u2_midrst_rdy", {31'b0, rdy_2}, 32'h0);
        check("u2_midrst_o1", o1_2, 32'h0);
        @(negedge clk);
        rstb2 = 1;
        n = 0;
        while (!rdy_2 && n < 100) begin
            step();
            n++;
        end
        check("u2_clr_cycles", n, 24);

        drive(0,0,4'h0,5'h02,32'hCAFEF00D, 1,1,4'hf,5'h00,32'h0, 0);
        step();
        drive(0,1,4'hf,5'h02,32'h0, 1,1,4'hf,5'h00,32'h0, 0);
        step();
        check("u2_lat_edge1", o1_2, 32'h0);
        drive(1,1,4'hf,5'h00,32'h0, 1,1,4'hf,5'h00,32'h0, 0);
        step();
        check("u2_lat_edge2", o1_2, 32'hCAFEF00D);

        drive(0,0,4'h0,5'h1a,32'h55, 0,0,4'h0,5'h1a,32'h66, 0);
        step();
        check("u2_oor_coll", {31'b0, coll_2}, 32'h0);
        drive(0,1,4'hf,5'h1a,32'h0, 1,1,4'hf,5'h00,32'h0, 0);
        step();
        drive(1,1,4'hf,5'h00,32'h0, 1,1,4'hf,5'h00,32'h0, 0);
        step();
        check("u2_oor_rd", o1_2, 32'h0);
        check("u2_oor_o2", o2_2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_cb_param.md
Name: dpram_cb_param

Overview:
Parametrised synchronous dual-port RAM. Next generation of the fixed 32x32 dual-port array, with configurable width and depth, byte-write masks, selectable read latency and read-during-write mode, collision detection, and an optional post-reset clear sequence. Both ports share one clock. Used as generic register-file and buffer storage in the datapath.

Parameters:
ADDR_W, 5, address width per port
DATA_W, 32, word width; must be a multiple of BYTE_W
BYTE_W, 8, byte-lane width for write masks
DEPTH, 2**ADDR_W, number of words; must be <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write: 0 returns old data (read-first), 1 returns new data (write-first)
INIT_CLR, 1, 1 = zero the array after reset; 0 = array contents undefined

Ports:
CLK  in  1  clock; all state updates on posedge
RSTB  in  1  asynchronous active-low reset
CSB1, CSB2  in  1  port chip select, active low
WEB1, WEB2  in  1  0 = write, 1 = read
OEB1, OEB2  in  1  output enable, active low, combinational on output
BWEB1, BWEB2  in  DATA_W/BYTE_W  byte write enable per lane, active low
A1, A2  in  ADDR_W  address
I1, I2  in  DATA_W  write data
O1, O2  out  DATA_W  read data
RDY  out  1  1 = array accepts accesses
COLL  out  1  one-cycle pulse: same-address conflict on the previous edge

Behaviour:
- Reset (RSTB = 0, asynchronous): all output pipeline registers = 0, COLL = 0, clear counter = 0. If INIT_CLR = 1, RDY = 0 and FSM = CLEAR; otherwise RDY = 1 and FSM = RUN. Array contents are not reset directly.
- FSM state CLEAR:
  - Writes zero to address cnt on each edge; cnt increments.
  - Port inputs are ignored; O1 and O2 hold 0.
  - When cnt = DEPTH-1 is written, next state is RUN and RDY = 1 from that edge.
  - The clear takes exactly DEPTH cycles after reset release.
  - Reset mid-clear restarts the sequence at cnt = 0.
- FSM state RUN:
  - Port n is active on an edge when RDY = 1 and CSBn = 0.
  - Write (WEBn = 0): lanes with BWEBn[k] = 0 take In; other lanes keep their old value.
  - Read (WEBn = 1): word at An reaches the final output register RD_LAT edges later.
  - Inactive cycles: the output pipeline holds its last value (no bubble to 0).
- Write-cycle output: on a write, the port's own output register loads the old word (RDW_MODE = 0) or the merged new word (RDW_MODE = 1).
- Output gating: On = OEBn ? 0 : final output register. No internal tristate.
- Same-address collisions (both ports active, A1 = A2):
  - Write/write: port 1 wins on lanes both ports enable. Lanes enabled only by port 2 take I2. COLL = 1 for one cycle after the edge.
  - Write/read: the reading port gets old or new data per RDW_MODE; COLL = 1.
  - Read/read: no collision; both ports get the word; COLL = 0.
- Out-of-range address (An >= DEPTH): write is ignored; read returns 0; no COLL.
- RD_LAT = 2: one extra register stage per port. OEB gates only the final stage.

Decomposition:
- Package dpram_pkg:
  - typedef enum {CLEAR, RUN} dpram_state_t
  - function byte_merge(old, new, bweb, lanes)
  - localparam NUM_LANES derivation helper
- Sub-module dpram_port_pipe: per-port output pipeline of depth RD_LAT with OEB gating; instantiated twice.
- Array, FSM, clear counter and collision logic stay in the top module.

Test Plan:
1. Default params; pulse RSTB low, release -> RDY rises after exactly 32 cycles; read addr 0x1f on port 1 -> O1 = 0x00000000.
2. Port 1 writes 0x7b @0x0f, then 0x67 @0x0a; port 1 reads 0x0f -> O1 = 0x0000007b one cycle later. Port 2 reads 0x0a with OEB2 = 0 -> O2 = 0x00000067; set OEB2 = 1 -> O2 = 0.
3. Addr 0x03 holds 0x11223344; port 1 writes 0xAABBCCDD with BWEB1 = 4'b1010 -> readback 0x11BB33DD.
4. Same edge: port 1 writes 0x1 @0x05 with BWEB1 = 0, port 2 writes 0x2 @0x05 with BWEB2 = 0 -> COLL = 1 for one cycle; readback 0x00000001.
5. Addr 0x07 holds 0x12345678; port 1 writes 0xDEAD0000 while port 2 reads 0x07 -> RDW_MODE = 0: O2 = 0x12345678; RDW_MODE = 1: O2 = 0xDEAD0000; COLL = 1 in both cases.
6. RD_LAT = 2, DEPTH = 24 variant: read of valid address -> data appears after 2 edges; write then read @0x1a -> O = 0, no COLL. RSTB pulsed at clear cycle 10 -> RDY = 0 until 24 cycles after release.
